// File: rtl/paddle_step_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : paddle_step_pkg
//  Description : Shared types and helpers for the paddle step decoder.
//                - channel FSM state encoding
//                - default position count and debounce length
//                - mod_delta(): forward distance from prev to cand on a ring
//                  of num_pos positions
//  Revision    : 1.0 - initial release
// ============================================================================
package paddle_step_pkg;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        SETTLE = 2'd2
    } step_state_e;

    localparam int c_DEF_NUM_POS      = 3;
    localparam int c_DEF_DEBOUNCE_CYC = 4;

    // Forward distance from prev to cand, modulo num_pos. Both operands are
    // assumed to be legal positions (< num_pos). The wrap branch adds num_pos
    // before subtracting so the intermediate never goes negative; the result
    // is always below num_pos and so fits in the caller's POS_W+1 bits.
    function automatic logic [31:0] mod_delta(input logic [31:0] cand,
                                              input logic [31:0] prev,
                                              input logic [31:0] num_pos);
        if (cand >= prev) begin
            return cand - prev;
        end
        return cand + num_pos - prev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/paddle_step_channel.sv
`default_nettype none
// ============================================================================
//  Module      : paddle_step_channel
//  Description : One switch channel: two-flop synchroniser, debounce FSM and
//                wrap-around direction decoder.
//  Ports       : clk       - system clock
//                rst       - synchronous active-high reset
//                en        - enables left/right/skip pulses
//                in_p      - raw switch code for this channel
//                left_op   - one-cycle left step pulse
//                right_op  - one-cycle right step pulse
//                skip_err  - one-cycle pulse, accepted code jumped > 1 step
//                bad_code  - one-cycle pulse, debounced code >= NUM_POS
//  Revision    : 1.0 - initial release
// ============================================================================
module paddle_step_channel
    import paddle_step_pkg::*;
#(
    parameter int NUM_POS      = c_DEF_NUM_POS,
    parameter int POS_W        = 2,
    parameter int DEBOUNCE_CYC = c_DEF_DEBOUNCE_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [POS_W-1:0] in_p,
    output logic             left_op,
    output logic             right_op,
    output logic             skip_err,
    output logic             bad_code
);

    // Counter must also hold DEBOUNCE_CYC, used as a "reported" marker in INIT.
    localparam int c_CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int c_DW    = POS_W + 1;

    localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_PARK = c_CNT_W'(DEBOUNCE_CYC);
    localparam logic [c_DW-1:0]    c_D_ONE    = c_DW'(1);
    localparam logic [c_DW-1:0]    c_D_BACK   = c_DW'(NUM_POS - 1);
    localparam logic [c_DW-1:0]    c_D_NPOS   = c_DW'(NUM_POS);

    step_state_e        r_state;
    logic [POS_W-1:0]   r_sync1;
    logic [POS_W-1:0]   r_sync2;
    logic [POS_W-1:0]   r_cand;
    logic [POS_W-1:0]   r_stable;
    logic [c_CNT_W-1:0] r_cnt;

    logic [c_DW-1:0]    w_delta;
    logic               w_cand_bad;

    assign w_cand_bad = ({1'b0, r_cand} >= c_D_NPOS);
    assign w_delta    = c_DW'(mod_delta(32'(r_cand), 32'(r_stable), 32'(NUM_POS)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= INIT;
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_cand   <= '0;
            r_stable <= '0;
            r_cnt    <= c_CNT_ZERO;
            left_op  <= 1'b0;
            right_op <= 1'b0;
            skip_err <= 1'b0;
            bad_code <= 1'b0;
        end else begin
            r_sync1  <= in_p;
            r_sync2  <= r_sync1;
            left_op  <= 1'b0;
            right_op <= 1'b0;
            skip_err <= 1'b0;
            bad_code <= 1'b0;

            case (r_state)
                INIT: begin
                    if (r_sync2 != r_cand) begin
                        r_cand <= r_sync2;
                        r_cnt  <= c_CNT_ZERO;
                    end else if (r_cnt == c_CNT_LAST) begin
                        if (w_cand_bad) begin
                            // Report once, then park until the code changes.
                            bad_code <= 1'b1;
                            r_cnt    <= c_CNT_PARK;
                        end else begin
                            // Power-up position is adopted silently.
                            r_stable <= r_cand;
                            r_state  <= IDLE;
                        end
                    end else if (r_cnt < c_CNT_LAST) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                IDLE: begin
                    if (r_sync2 != r_stable) begin
                        r_cand  <= r_sync2;
                        r_cnt   <= c_CNT_ZERO;
                        r_state <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (r_sync2 == r_stable) begin
                        r_state <= IDLE;
                    end else if (r_sync2 != r_cand) begin
                        r_cand <= r_sync2;
                        r_cnt  <= c_CNT_ZERO;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_state <= IDLE;
                        if (w_cand_bad) begin
                            bad_code <= 1'b1;
                        end else begin
                            // Stable position tracks even while en is low.
                            r_stable <= r_cand;
                            if (w_delta == c_D_ONE) begin
                                right_op <= en;
                            end else if (w_delta == c_D_BACK) begin
                                left_op  <= en;
                            end else begin
                                skip_err <= en;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/paddle_step_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : paddle_step_decoder
//  Description : Multi-channel rotary/dip-switch step decoder. Each channel
//                debounces its position code and emits one-cycle left/right
//                step pulses with wrap-around direction logic, plus skipped-
//                position and invalid-code error pulses.
//  Ports       : clk       - system clock
//                rst       - synchronous active-high reset
//                en        - enables step and skip pulses
//                in_p      - raw codes, channel c at [c*POS_W +: POS_W]
//                left_op   - per-channel left step pulse
//                right_op  - per-channel right step pulse
//                skip_err  - per-channel skipped-position pulse
//                bad_code  - per-channel invalid-code pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module paddle_step_decoder
    import paddle_step_pkg::*;
#(
    parameter int CH           = 2,
    parameter int NUM_POS      = c_DEF_NUM_POS,
    parameter int POS_W        = 2,
    parameter int DEBOUNCE_CYC = c_DEF_DEBOUNCE_CYC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CH*POS_W-1:0] in_p,
    output logic [CH-1:0]       left_op,
    output logic [CH-1:0]       right_op,
    output logic [CH-1:0]       skip_err,
    output logic [CH-1:0]       bad_code
);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        paddle_step_channel #(
            .NUM_POS      (NUM_POS),
            .POS_W        (POS_W),
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_channel (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .in_p     (in_p[c*POS_W +: POS_W]),
            .left_op  (left_op[c]),
            .right_op (right_op[c]),
            .skip_err (skip_err[c]),
            .bad_code (bad_code[c])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_paddle_step_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_paddle_step_decoder
//  Description : Self-checking bench. Two decoder builds (NUM_POS=3 and
//                NUM_POS=5) run side by side against a run-length reference
//                model; directed scenarios add fixed-value latency and pulse
//                count checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_paddle_step_decoder;

    localparam int DEB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic en  = 1'b1;
    int   pin [2][2];     // [build][channel]

    logic [3:0] in_a;
    logic [5:0] in_b;
    logic [1:0] la, ra, sa, ba, lb, rb, sb, bb;

    assign in_a = {pin[0][1][1:0], pin[0][0][1:0]};
    assign in_b = {pin[1][1][2:0], pin[1][0][2:0]};

    paddle_step_decoder #(.CH(2), .NUM_POS(3), .POS_W(2), .DEBOUNCE_CYC(DEB)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .in_p(in_a),
        .left_op(la), .right_op(ra), .skip_err(sa), .bad_code(ba)
    );

    paddle_step_decoder #(.CH(2), .NUM_POS(5), .POS_W(3), .DEBOUNCE_CYC(DEB)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .in_p(in_b),
        .left_op(lb), .right_op(rb), .skip_err(sb), .bad_code(bb)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A code is accepted once the synchronised value has been seen for DEB+1
    // consecutive edges; a rejected (illegal) code keeps re-triggering every
    // DEB+1 edges, except during power-up where it is reported once per run.
    int np_of [2] = '{3, 5};
    int m_s1 [2][2], m_s2 [2][2], m_seen [2][2], m_run [2][2], m_stable [2][2];
    bit m_init [2][2];
    bit e_l [2][2], e_r [2][2], e_s [2][2], e_b [2][2];

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 2; c++) begin
                int v, d, np;
                np = np_of[i];
                e_l[i][c] = 0; e_r[i][c] = 0; e_s[i][c] = 0; e_b[i][c] = 0;
                if (rst) begin
                    m_s1[i][c] = 0; m_s2[i][c] = 0; m_seen[i][c] = 0;
                    m_run[i][c] = 1; m_stable[i][c] = 0; m_init[i][c] = 1;
                end else begin
                    v = m_s2[i][c];
                    if (v == m_seen[i][c]) m_run[i][c]++;
                    else m_run[i][c] = 1;
                    m_seen[i][c] = v;
                    if (m_init[i][c]) begin
                        if (m_run[i][c] == DEB + 1) begin
                            if (v >= np) e_b[i][c] = 1;
                            else begin m_stable[i][c] = v; m_init[i][c] = 0; end
                        end
                    end else if (v != m_stable[i][c] && (m_run[i][c] % (DEB + 1)) == 0) begin
                        if (v >= np) e_b[i][c] = 1;
                        else begin
                            d = ((v - m_stable[i][c]) % np + np) % np;
                            if (en) begin
                                if (d == 1) e_r[i][c] = 1;
                                else if (d == np - 1) e_l[i][c] = 1;
                                else e_s[i][c] = 1;
                            end
                            m_stable[i][c] = v;
                        end
                    end
                    m_s2[i][c] = m_s1[i][c];
                    m_s1[i][c] = pin[i][c];
                end
            end
        end
    endtask

    // pulse counters: [build][kind 0=left 1=right 2=skip 3=bad][channel]
    int pc [2][4][2];
    int both_right;

    function automatic logic out_bit(input int i, input int k, input int c);
        logic [1:0] v;
        case ({i[0], k[1:0]})
            3'b000: v = la; 3'b001: v = ra; 3'b010: v = sa; 3'b011: v = ba;
            3'b100: v = lb; 3'b101: v = rb; 3'b110: v = sb; default: v = bb;
        endcase
        return v[c[0]];
    endfunction

    task automatic clr_counts();
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++)
                for (int c = 0; c < 2; c++) pc[i][k][c] = 0;
        both_right = 0;
    endtask

    function automatic int sum_counts(input int i);
        int s = 0;
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 2; c++) s += pc[i][k][c];
        return s;
    endfunction

    // One clock edge: advance model, sample DUT 1 time unit later, compare.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("a_left",  32'(la), 32'({e_l[0][1], e_l[0][0]}));
        check("a_right", 32'(ra), 32'({e_r[0][1], e_r[0][0]}));
        check("a_skip",  32'(sa), 32'({e_s[0][1], e_s[0][0]}));
        check("a_bad",   32'(ba), 32'({e_b[0][1], e_b[0][0]}));
        check("b_left",  32'(lb), 32'({e_l[1][1], e_l[1][0]}));
        check("b_right", 32'(rb), 32'({e_r[1][1], e_r[1][0]}));
        check("b_skip",  32'(sb), 32'({e_s[1][1], e_s[1][0]}));
        check("b_bad",   32'(bb), 32'({e_b[1][1], e_b[1][0]}));
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++)
                for (int c = 0; c < 2; c++)
                    if (out_bit(i, k, c)) pc[i][k][c]++;
        if (ra == 2'b11) both_right++;
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    // Ticks until the selected pulse appears; k = edges counted from the
    // change (first edge = 1), or -1 when the budget runs out.
    task automatic wait_pulse(input int i, input int kind, input int c,
                              input int max, output int k);
        k = -1;
        for (int j = 1; j <= max; j++) begin
            tick();
            if (out_bit(i, kind, c)) begin k = j; break; end
        end
    endtask

    int lat;

    initial begin
        for (int i = 0; i < 2; i++)
            for (int c = 0; c < 2; c++) pin[i][c] = 0;
        clr_counts();

        // 1. power-up position is silent; 2->0 is a right step, 7 edges later
        pin[0][0] = 2;
        rst = 1'b1;
        run(3);
        check("reset_outputs", 32'({la, ra, sa, ba, lb, rb, sb, bb}), 32'd0);
        rst = 1'b0;
        clr_counts();
        run(20);
        check("powerup_silent", 32'(sum_counts(0) + sum_counts(1)), 32'd0);
        pin[0][0] = 0;
        wait_pulse(0, 1, 0, 15, lat);
        check("right_latency", 32'(lat), 32'd7);
        run(1);
        check("right_one_cycle", 32'(ra[0]), 32'd0);

        // 2. full rotation both ways
        run(10);
        clr_counts();
        pin[0][0] = 1; run(10); pin[0][0] = 2; run(10); pin[0][0] = 0; run(10);
        check("rot_right_cnt", 32'(pc[0][1][0]), 32'd3);
        pin[0][0] = 2; run(10); pin[0][0] = 1; run(10); pin[0][0] = 0; run(10);
        check("rot_left_cnt", 32'(pc[0][0][0]), 32'd3);
        check("rot_right_total", 32'(pc[0][1][0]), 32'd3);
        check("rot_ch1_silent", 32'(pc[0][0][1] + pc[0][1][1] + pc[0][2][1] + pc[0][3][1]), 32'd0);

        // 3. bounce then settle; short glitch is ignored
        clr_counts();
        pin[0][0] = 1; run(2); pin[0][0] = 0; run(2); pin[0][0] = 1; run(2);
        pin[0][0] = 0; run(2); pin[0][0] = 1;
        wait_pulse(0, 1, 0, 15, lat);
        check("bounce_latency", 32'(lat), 32'(DEB + 3));
        run(10);
        check("bounce_one_pulse", 32'(pc[0][1][0]), 32'd1);
        pin[0][0] = 0; run(12);
        clr_counts();
        pin[0][0] = 1; run(3); pin[0][0] = 0; run(20);
        check("glitch_silent", 32'(sum_counts(0)), 32'd0);

        // 5. enable gating, no catch-up
        clr_counts();
        en = 1'b0; pin[0][0] = 1; run(12);
        check("en_low_silent", 32'(sum_counts(0)), 32'd0);
        en = 1'b1; pin[0][0] = 2; run(12);
        check("en_right_cnt", 32'(pc[0][1][0]), 32'd1);
        check("en_no_left", 32'(pc[0][0][0]), 32'd0);

        // 6. simultaneous steps, then reset mid-SETTLE
        clr_counts();
        pin[0][0] = 0; pin[0][1] = 1; run(12);
        check("both_right", 32'(both_right), 32'd1);
        clr_counts();
        pin[0][0] = 1; run(4);
        rst = 1'b1; run(1);
        check("rst_mid_settle", 32'({la, ra, sa, ba}), 32'd0);
        run(2);
        rst = 1'b0; run(15);
        check("rst_no_pulse", 32'(sum_counts(0)), 32'd0);

        // 4. NUM_POS=5 build, channel 1
        pin[1][1] = 1; run(12);
        clr_counts();
        pin[1][1] = 3; run(12);
        check("b_skip_cnt", 32'(pc[1][2][1]), 32'd1);
        check("b_skip_nostep", 32'(pc[1][0][1] + pc[1][1][1]), 32'd0);
        pin[1][1] = 4; run(12);
        check("b_step34", 32'(pc[1][1][1]), 32'd1);
        clr_counts();
        pin[1][1] = 6; run(12);
        check("b_bad_seen", 32'(pc[1][3][1] != 0), 32'd1);
        check("b_bad_nostep", 32'(pc[1][0][1] + pc[1][1][1] + pc[1][2][1]), 32'd0);
        pin[1][1] = 0; run(12);
        check("b_step40", 32'(pc[1][1][1]), 32'd1);

        // randomized traffic on both builds against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                int i, c;
                i = $urandom_range(0, 1);
                c = $urandom_range(0, 1);
                pin[i][c] = (i == 0) ? $urandom_range(0, 3) : $urandom_range(0, 7);
            end
            if ($urandom_range(0, 19) == 0) en = ~en;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;
        run(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/paddle_step_decoder.md
Name: paddle_step_decoder

Overview:
- Multi-channel successor to the pong dip-switch direction decoder.
- Each channel watches an N-position rotary/dip-switch code. It synchronises and debounces the code, then emits one-cycle left/right step pulses using modular, wrap-around direction logic.
- Feeds the paddle position logic: one channel per player.
- Adds an enable gate plus invalid-code and skipped-position error pulses.

Parameters:
- CH, 2, number of independent switch channels (players).
- NUM_POS, 3, number of legal switch positions; legal codes are 0..NUM_POS-1; must be at least 3.
- POS_W, 2, width of one channel's position code; must be at least clog2(NUM_POS).
- DEBOUNCE_CYC, 4, consecutive stable cycles required before a new code is accepted; must be at least 1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  step pulses are produced only while high; tracking continues while low.
- in_p  in  CH*POS_W  raw switch codes; channel c occupies bits [c*POS_W +: POS_W].
- left_op  out  CH  one-cycle left step pulse per channel.
- right_op  out  CH  one-cycle right step pulse per channel.
- skip_err  out  CH  one-cycle pulse: accepted code jumped by more than one position.
- bad_code  out  CH  one-cycle pulse: a debounced code was NUM_POS or greater.

Behaviour:
- Reset:
  - All outputs are 0.
  - Sync flops, candidate and stable position are cleared to 0.
  - Debounce counter is 0.
  - Every channel enters state INIT.
- Synchroniser: two flops per channel bit on in_p; all logic uses the second stage.
- Per-channel FSM has three states: INIT, IDLE, SETTLE.
  - INIT: waits for the synchronised code to be held DEBOUNCE_CYC cycles. It then loads the stable position and moves to IDLE. No pulse is ever produced from INIT, so the power-up position never moves the paddle. An illegal code held in INIT pulses bad_code and stays in INIT.
  - IDLE: when the synchronised code differs from the stable position, load the candidate, clear the counter and go to SETTLE.
  - SETTLE: while the synchronised code equals the candidate, the counter increments. If the code changes, reload the candidate and clear the counter (stay in SETTLE). If the code returns to the stable position, go to IDLE with no pulse. When the counter reaches DEBOUNCE_CYC-1 with the code still equal to the candidate, accept the candidate and go to IDLE.
- Acceptance:
  - If the candidate is NUM_POS or greater: pulse bad_code; the stable position is unchanged.
  - Otherwise compute d = (cand - stable) mod NUM_POS, using POS_W+1-bit arithmetic with no truncation error.
  - d == 1: pulse right_op.
  - d == NUM_POS-1: pulse left_op.
  - Any other d (possible only when NUM_POS is 4 or more): pulse skip_err with no step.
  - The stable position is then updated to the candidate.
- Wrap-around examples for NUM_POS=3:
  - Right steps: 0->1, 1->2, 2->0.
  - Left steps: 1->0, 2->1, 0->2.
- Latency:
  - The pin value is changed before edge E0 and held.
  - The pulse is high for exactly one cycle, the cycle after edge E0+DEBOUNCE_CYC+2.
  - Total pin-to-pulse latency is DEBOUNCE_CYC+3 edges.
- Pulse exclusivity: left_op, right_op, skip_err and bad_code are mutually exclusive within a channel.
- Enable gating: while en=0, left_op, right_op and skip_err are forced to 0, but the stable position still updates. No catch-up pulses are issued when en rises. bad_code is not gated by en.
- Channel independence: channels are independent, and simultaneous pulses on different channels are legal.
- Reset mid-SETTLE: the pending candidate is discarded and no pulse is produced.

Decomposition:
- Package paddle_step_pkg holds:
  - the state encoding (INIT=2'd0, IDLE=2'd1, SETTLE=2'd2);
  - the default NUM_POS and DEBOUNCE_CYC;
  - a function mod_delta(cand, prev, num_pos).
- Sub-module paddle_step_channel: one synchroniser, FSM and decoder per channel.
- Top module: a generate loop over CH that slices in_p and concatenates the outputs.

Test Plan:
1. Power-up: reset, hold in_p ch0=2, wait 20 cycles -> no pulses on any output; then ch0 2->0 -> right_op[0] high for exactly one cycle, 7 edges after the change.
2. Full rotation, NUM_POS=3: ch0 sequence 0,1,2,0 then 0,2,1,0, each value held 10 cycles -> right_op[0] pulses 3 times, then left_op[0] pulses 3 times; channel 1 stays silent.
3. Bounce: ch0 toggles 0->1->0->1 with 2-cycle dwell, then holds 1 -> exactly one right_op[0] pulse, issued DEBOUNCE_CYC+3 edges after the final edge; a 3-cycle glitch 0->1->0 produces no pulse.
4. NUM_POS=5 build: ch1 1->3 -> skip_err[1] pulse with no left/right pulse; then 3->4 -> right_op[1] pulse. Code 6 held -> bad_code[1] pulse, and a following 4->0 still yields right_op[1].
5. Enable: en=0, ch0 0->1 -> no pulse; en=1, ch0 1->2 -> single right_op[0] pulse, with no catch-up pulse for 0->1.
6. Simultaneous events and reset: both channels step right on the same cycle -> right_op=2'b11 for one cycle; rst asserted mid-SETTLE -> no pulse and all outputs 0 on the next cycle.
